// File: rtl/route_edge_scheduler.sv
// route_edge_scheduler
//   Walks the DFG edge list through the X-then-Y router core. The host loads
//   edges while the block is idle and then pulses start. Each edge is offered
//   to the router over a valid/ready handshake, and the block then waits for
//   the router's pass/fail strobe. An edge that fails goes back on the tail of
//   the queue to be retried, up to MAX_RETRY times. After that it is counted
//   as abandoned.
//
// Optional feature (compile-time macro ROUTE_SCHED_TIMEOUT_EN):
//   A watchdog in WAIT. If no result arrives within TIMEOUT cycles, the edge
//   is treated as blocked. Without the macro, WAIT holds until res_valid.
//
// Ports:
//   clk, reset (async, active-low)
//   start                            begin a pass (sampled in IDLE only)
//   load_valid/load_edge/load_ready  host edge loading (IDLE only; 0 = terminator)
//   disp_valid/disp_edge/disp_first/disp_ready  edge offer to the router
//   res_valid/res_ok                 router result strobe
//   busy, done, fail                 pass status
//   routed_cnt, failed_cnt           saturating per-pass result counters
module route_edge_scheduler #(
  parameter int EDGE_W    = 8,
  parameter int DEPTH     = 16,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_valid,
  input  logic [EDGE_W-1:0] load_edge,
  output logic              load_ready,
  output logic              disp_valid,
  output logic [EDGE_W-1:0] disp_edge,
  output logic              disp_first,
  input  logic              disp_ready,
  input  logic              res_valid,
  input  logic              res_ok,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [CNT_W-1:0]  routed_cnt,
  output logic [CNT_W-1:0]  failed_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = EDGE_W + 2;
  localparam logic [1:0]       MAX_RETRY_L = 2'(MAX_RETRY);
  localparam logic [OCC_W-1:0] FULL_L      = OCC_W'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DISPATCH, S_WAIT, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0]    count_q, count_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic [1:0]          retry_q, retry_d;
  logic                first_q, first_d;
  logic                disp_valid_q, disp_valid_d;
  logic                load_ready_q, load_ready_d;
  logic                busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [CNT_W-1:0]    routed_q, routed_d, failed_q, failed_d;

  logic [ENT_W-1:0]    queue_mem [DEPTH];
  logic [ENT_W-1:0]    head_entry_s, push_entry_s;
  logic                push_s, pop_s, timeout_s, res_event_s, res_good_s;

  // Saturating counter increment: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

`ifdef ROUTE_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q, wd_d;

  // Watchdog: cleared on the way into WAIT, fires on the TIMEOUT-th WAIT cycle.
  always_comb begin
    wd_d = wd_q;
    if (state_q == S_DISPATCH) begin
      wd_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = wd_q;
    end
  end

  // Watchdog register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wd_q <= '0;
    else        wd_q <= wd_d;
  end

  assign timeout_s = (state_q == S_WAIT) && (wd_q == WD_W'(TIMEOUT - 1));
`else
  // No watchdog in this build; the comparison is constant-false.
  assign timeout_s = (TIMEOUT < 0);
`endif

  assign head_entry_s = queue_mem[head_q];
  // A real result always takes priority over a watchdog expiry.
  assign res_event_s  = (state_q == S_WAIT) && (res_valid || timeout_s);
  assign res_good_s   = res_valid && res_ok;

  // Queue push/pop decode. Pushes come from loading (IDLE) or requeue (WAIT),
  // and pops happen only in FETCH, so the two never coincide.
  always_comb begin
    push_s       = 1'b0;
    pop_s        = 1'b0;
    push_entry_s = '0;
    case (state_q)
      S_IDLE: begin
        if (load_valid && load_ready_q && (load_edge != '0)) begin
          push_s       = 1'b1;
          push_entry_s = {load_edge, 2'b00};
        end else begin
          push_s = 1'b0;
        end
      end
      S_FETCH: pop_s = 1'b1;
      S_WAIT: begin
        if (res_event_s && !res_good_s && (retry_q < MAX_RETRY_L)) begin
          push_s       = 1'b1;
          push_entry_s = {edge_q, retry_q + 2'd1};
        end else begin
          push_s = 1'b0;
        end
      end
      default: begin
        push_s = 1'b0;
        pop_s  = 1'b0;
      end
    endcase
  end

  // Queue pointers and occupancy. Power-of-two DEPTH wraps by overflow.
  always_comb begin
    head_d  = pop_s  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push_s ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + (push_s ? OCC_W'(1) : OCC_W'(0)) - (pop_s ? OCC_W'(1) : OCC_W'(0));
  end

  // Queue storage (data only; validity is tracked by head/tail/count).
  always_ff @(posedge clk) begin
    if (push_s) queue_mem[tail_q] <= push_entry_s;
  end

  // Scheduler next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    edge_d       = edge_q;
    retry_d      = retry_q;
    first_d      = first_q;
    disp_valid_d = disp_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fail_d       = fail_q;
    routed_d     = routed_q;
    failed_d     = failed_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          routed_d = '0;
          failed_d = '0;
          fail_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = (count_d != '0) ? S_FETCH : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        edge_d       = head_entry_s[ENT_W-1:2];
        retry_d      = head_entry_s[1:0];
        first_d      = (head_entry_s[1:0] == 2'b00);
        disp_valid_d = 1'b1;
        state_d      = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (disp_ready) begin
          disp_valid_d = 1'b0;
          state_d      = S_WAIT;
        end else begin
          state_d = S_DISPATCH;
        end
      end
      S_WAIT: begin
        if (res_event_s) begin
          if (res_good_s) begin
            routed_d = sat_inc(routed_q);
          end else if (retry_q >= MAX_RETRY_L) begin
            failed_d = sat_inc(failed_q);
          end else begin
            failed_d = failed_q;
          end
          state_d = (count_d != '0) ? S_FETCH : S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        fail_d  = (failed_q != '0);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    load_ready_d = (state_d == S_IDLE) && (count_d != FULL_L);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      edge_q       <= '0;
      retry_q      <= 2'b00;
      first_q      <= 1'b0;
      disp_valid_q <= 1'b0;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      routed_q     <= '0;
      failed_q     <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      edge_q       <= edge_d;
      retry_q      <= retry_d;
      first_q      <= first_d;
      disp_valid_q <= disp_valid_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      routed_q     <= routed_d;
      failed_q     <= failed_d;
    end
  end

  assign load_ready = load_ready_q;
  assign disp_valid = disp_valid_q;
  assign disp_edge  = edge_q;
  assign disp_first = first_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign fail       = fail_q;
  assign routed_cnt = routed_q;
  assign failed_cnt = failed_q;

endmodule

// File: tb/tb_route_edge_scheduler.sv
module tb_route_edge_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_edge = 8'h00;
  logic       load_ready;
  logic       disp_valid;
  logic [7:0] disp_edge;
  logic       disp_first;
  logic       disp_ready = 1'b0;
  logic       res_valid = 1'b0;
  logic       res_ok = 1'b0;
  logic       busy, done, fail;
  logic [4:0] routed_cnt, failed_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] got_edge [64];
  logic       got_first [64];
  int         n_disp, done_cnt, first_lat;

  route_edge_scheduler dut (
    .clk(clk), .reset(reset), .start(start),
    .load_valid(load_valid), .load_edge(load_edge), .load_ready(load_ready),
    .disp_valid(disp_valid), .disp_edge(disp_edge), .disp_first(disp_first),
    .disp_ready(disp_ready), .res_valid(res_valid), .res_ok(res_ok),
    .busy(busy), .done(done), .fail(fail),
    .routed_cnt(routed_cnt), .failed_cnt(failed_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] e);
    load_valid = 1'b1;
    load_edge  = e;
    tick();
    load_valid = 1'b0;
    load_edge  = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Router model: always ready; answers each dispatch one cycle after the
  // handshake with res_ok taken from ok_mask bit [dispatch index].
  task automatic serve(input logic [63:0] ok_mask, input int budget);
    logic pending;
    int   post;
    n_disp = 0; done_cnt = 0; first_lat = -1; pending = 1'b0; post = 0;
    disp_ready = 1'b1;
    for (int c = 1; c <= budget && post < 4; c++) begin
      tick();
      res_valid = 1'b0;
      res_ok    = 1'b0;
      if (pending) begin
        res_valid = 1'b1;
        res_ok    = ok_mask[n_disp-1];
        pending   = 1'b0;
      end
      if (disp_valid) begin
        if (first_lat < 0) first_lat = c;
        if (n_disp < 64) begin
          got_edge[n_disp]  = disp_edge;
          got_first[n_disp] = disp_first;
        end
        n_disp++;
        pending = 1'b1;
      end
      if (done) done_cnt++;
      if (done_cnt > 0) post++;
    end
    res_valid = 1'b0;
    res_ok    = 1'b0;
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL serve_budget: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({load_ready, disp_valid, busy, done, fail, routed_cnt, failed_cnt} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %h exp 0", {load_ready, disp_valid, busy, done, fail, routed_cnt, failed_cnt});
    end
    reset = 1'b1;
    tick();
    checks++;
    if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_load_ready: got %b exp 1", load_ready); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_e [3];
    exp_e = '{8'h12, 8'h25, 8'h3F};
    for (int i = 0; i < 3; i++) load(exp_e[i]);
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b exp 1", busy); end
    serve(64'hFFFF_FFFF_FFFF_FFFF, 60);
    checks++;
    if (n_disp != 3) begin failures++; $display("FAIL basic_ndisp: got %0d exp 3", n_disp); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_edge[i] !== exp_e[i] || got_first[i] !== 1'b1) begin
        failures++;
        $display("FAIL basic_disp%0d: got %h/%b exp %h/1", i, got_edge[i], got_first[i], exp_e[i]);
      end
    end
    checks++;
    if (first_lat != 1) begin failures++; $display("FAIL basic_latency: got %0d exp 1 cycle after start edge", first_lat); end
    checks++;
    if (routed_cnt !== 5'd3 || failed_cnt !== 5'd0 || fail !== 1'b0 || done_cnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: got r=%0d f=%0d fail=%b dones=%0d busy=%b exp 3 0 0 1 0",
               routed_cnt, failed_cnt, fail, done_cnt, busy);
    end
  endtask

  task automatic test_retry();
    logic [7:0] exp_e [3];
    logic       exp_f [3];
    exp_e = '{8'h12, 8'h34, 8'h12};
    exp_f = '{1'b1, 1'b1, 1'b0};
    load(8'h12);
    load(8'h34);
    pulse_start();
    serve(64'hFFFF_FFFF_FFFF_FFFE, 60);
    checks++;
    if (n_disp != 3) begin failures++; $display("FAIL retry_ndisp: got %0d exp 3", n_disp); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_edge[i] !== exp_e[i] || got_first[i] !== exp_f[i]) begin
        failures++;
        $display("FAIL retry_disp%0d: got %h/%b exp %h/%b", i, got_edge[i], got_first[i], exp_e[i], exp_f[i]);
      end
    end
    checks++;
    if (routed_cnt !== 5'd2 || failed_cnt !== 5'd0 || fail !== 1'b0 || done_cnt != 1) begin
      failures++;
      $display("FAIL retry_result: got r=%0d f=%0d fail=%b dones=%0d exp 2 0 0 1", routed_cnt, failed_cnt, fail, done_cnt);
    end
  endtask

  task automatic test_exhaust();
    logic exp_f [3];
    exp_f = '{1'b1, 1'b0, 1'b0};
    load(8'h56);
    pulse_start();
    serve(64'h0, 60);
    checks++;
    if (n_disp != 3) begin failures++; $display("FAIL exhaust_ndisp: got %0d exp 3", n_disp); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (got_edge[i] !== 8'h56 || got_first[i] !== exp_f[i]) begin
        failures++;
        $display("FAIL exhaust_disp%0d: got %h/%b exp 56/%b", i, got_edge[i], got_first[i], exp_f[i]);
      end
    end
    checks++;
    if (routed_cnt !== 5'd0 || failed_cnt !== 5'd1 || fail !== 1'b1 || done_cnt != 1) begin
      failures++;
      $display("FAIL exhaust_result: got r=%0d f=%0d fail=%b dones=%0d exp 0 1 1 1", routed_cnt, failed_cnt, fail, done_cnt);
    end
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (fail !== 1'b1) begin failures++; $display("FAIL exhaust_fail_held: got %b exp 1", fail); end
  endtask

  task automatic test_empty();
    load(8'h00);
    checks++;
    if (load_ready !== 1'b1) begin failures++; $display("FAIL empty_term_ready: got %b exp 1", load_ready); end
    pulse_start();
    checks++;
    if (fail !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL empty_clear: got fail=%b done=%b exp 0 0", fail, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || disp_valid !== 1'b0 || routed_cnt !== 5'd0 || failed_cnt !== 5'd0) begin
      failures++;
      $display("FAIL empty_done: got done=%b dv=%b r=%0d f=%0d exp 1 0 0 0", done, disp_valid, routed_cnt, failed_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL empty_pulse: got done=%b exp 0", done); end
  endtask

  task automatic test_full();
    for (int i = 1; i <= 16; i++) begin
      load(8'(i));
      if (i == 15) begin
        checks++;
        if (load_ready !== 1'b1) begin failures++; $display("FAIL full_ready15: got %b exp 1", load_ready); end
      end
    end
    checks++;
    if (load_ready !== 1'b0) begin failures++; $display("FAIL full_ready16: got %b exp 0", load_ready); end
    load(8'h11);
    pulse_start();
    serve(64'hFFFF_FFFF_FFFF_FFFF, 200);
    checks++;
    if (n_disp != 16 || routed_cnt !== 5'd16) begin
      failures++;
      $display("FAIL full_count: got ndisp=%0d r=%0d exp 16 16", n_disp, routed_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got_edge[i] !== 8'(i + 1)) begin
        failures++;
        $display("FAIL full_order%0d: got %h exp %h", i, got_edge[i], 8'(i + 1));
      end
    end
  endtask

  task automatic test_stall();
    int extra, dones;
    load(8'h7A);
    disp_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (disp_valid !== 1'b1 || disp_edge !== 8'h7A || disp_first !== 1'b1 || load_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold%0d: got dv=%b e=%h f=%b lr=%b exp 1 7a 1 0", i, disp_valid, disp_edge, disp_first, load_ready);
      end
    end
    disp_ready = 1'b1;
    tick();
    checks++;
    if (disp_valid !== 1'b0) begin failures++; $display("FAIL stall_release: got dv=%b exp 0", disp_valid); end
    res_valid = 1'b1;
    res_ok    = 1'b1;
    tick();
    res_valid = 1'b0;
    res_ok    = 1'b0;
    extra = 0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (disp_valid) extra++;
      if (done) dones++;
      tick();
    end
    checks++;
    if (extra != 0 || dones != 1 || routed_cnt !== 5'd1) begin
      failures++;
      $display("FAIL stall_result: got extra=%0d dones=%0d r=%0d exp 0 1 1", extra, dones, routed_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    load(8'h21);
    load(8'h22);
    disp_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    res_valid = 1'b1;
    res_ok    = 1'b1;
    tick();
    res_valid = 1'b0;
    res_ok    = 1'b0;
    tick();
    tick();
    checks++;
    if (routed_cnt !== 5'd1 || busy !== 1'b1 || disp_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_pre: got r=%0d busy=%b dv=%b exp 1 1 0", routed_cnt, busy, disp_valid);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || routed_cnt !== 5'd0 || failed_cnt !== 5'd0 || fail !== 1'b0) begin
      failures++;
      $display("FAIL rmid_reset: got busy=%b done=%b r=%0d f=%0d fail=%b exp all 0", busy, done, routed_cnt, failed_cnt, fail);
    end
    tick();
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) dones++;
    end
    checks++;
    if (dones != 0 || load_ready !== 1'b1) begin
      failures++;
      $display("FAIL rmid_nodone: got dones=%0d lr=%b exp 0 1", dones, load_ready);
    end
    pulse_start();
    tick();
    checks++;
    if (done !== 1'b1 || disp_valid !== 1'b0 || routed_cnt !== 5'd0 || failed_cnt !== 5'd0) begin
      failures++;
      $display("FAIL rmid_empty: got done=%b dv=%b r=%0d f=%0d exp 1 0 0 0", done, disp_valid, routed_cnt, failed_cnt);
    end
  endtask

`ifdef ROUTE_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int gap, dones;
    load(8'h45);
    disp_ready = 1'b1;
    pulse_start();
    tick();
    tick();
    gap = -1;
    for (int c = 1; c <= 80 && gap < 0; c++) begin
      tick();
      if (disp_valid) gap = c;
    end
    checks++;
    if (gap != 65 || disp_edge !== 8'h45 || disp_first !== 1'b0) begin
      failures++;
      $display("FAIL timeout_requeue: got gap=%0d e=%h f=%b exp 65 45 0", gap, disp_edge, disp_first);
    end
    dones = 0;
    for (int c = 0; c < 300 && dones == 0; c++) begin
      tick();
      if (done) dones++;
    end
    checks++;
    if (dones != 1 || failed_cnt !== 5'd1 || fail !== 1'b1) begin
      failures++;
      $display("FAIL timeout_abandon: got dones=%0d f=%0d fail=%b exp 1 1 1", dones, failed_cnt, fail);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_exhaust();
    test_empty();
    test_full();
    test_stall();
    test_reset_mid();
`ifdef ROUTE_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
